// File: rtl/seg_mux_display.sv
// seg_mux_display: time-multiplexed driver for an N-digit common-anode seven-segment display.
// Frame-coherent hex capture, 0-F decode, per-digit decimal points and optional leading-zero blanking.
`default_nettype none

module seg_mux_display #(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_DIV   = 100000,
  parameter int BLANK_LEADING = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_en,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int PW    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  logic [PW-1:0]           presc;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] value_snap;
  logic [NUM_DIGITS-1:0]   dp_snap;

  logic                    tick;
  logic                    wrap;
  logic [NUM_DIGITS-1:0]   keep;
  logic                    blank_acc;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_keep;
  logic [NUM_DIGITS-1:0]   an_next;
  logic [7:0]              seg_next;

  // Returns segments a..g, active-low.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0001100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  assign tick = (presc == PRESC_LAST);
  assign wrap = tick && (idx == IDX_LAST);

  // A digit stays lit once any nibble or dp at or above it is non-zero.
  always_comb begin
    keep      = '0;
    blank_acc = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      blank_acc = blank_acc | (|value_snap[4*k +: 4]) | dp_snap[k];
      keep[k]   = blank_acc;
    end
    keep[0] = 1'b1;
    if (BLANK_LEADING == 0) begin
      keep = '1;
    end
  end

  always_comb begin
    cur_nib  = 4'h0;
    cur_dp   = 1'b0;
    cur_keep = 1'b0;
    an_next  = '1;
    seg_next = 8'hFF;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_nib  = value_snap[4*k +: 4];
        cur_dp   = dp_snap[k];
        cur_keep = keep[k];
      end
    end
    if (en && cur_keep) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        an_next[k] = (idx != IDX_W'(k));
      end
      seg_next = {hex_to_seg(cur_nib), ~cur_dp};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc      <= '0;
      idx        <= '0;
      value_snap <= '0;
      dp_snap    <= '0;
      frame_done <= 1'b0;
      an         <= '1;
      seg        <= 8'hFF;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) begin
        idx <= wrap ? '0 : idx + 1'b1;
      end
      if (wrap) begin
        value_snap <= value;
        dp_snap    <= dp_en;
      end
      frame_done <= wrap;
      an         <= an_next;
      seg        <= seg_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg_mux_display.sv
// Directed scoreboard bench for seg_mux_display (4 digits, 4 clk per digit, blanking on).
`default_nettype none

module tb_seg_mux_display;

  localparam int ND = 4;
  localparam int RD = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [15:0]   value;
  logic [3:0]    dp_en;
  logic [7:0]    seg;
  logic [3:0]    an;
  logic          frame_done;

  int tests = 0;
  int fails = 0;

  logic [3:0] exp_an_q[$];
  logic [7:0] exp_seg_q[$];

  seg_mux_display #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RD),
    .BLANK_LEADING(1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .value     (value),
    .dp_en     (dp_en),
    .seg       (seg),
    .an        (an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Table as written: a,b,c,d,e,f,g,dp with dp off.
  function automatic logic [7:0] ref_pattern(input logic [3:0] nib);
    case (nib)
      4'h0: return 8'b00000011;
      4'h1: return 8'b10011111;
      4'h2: return 8'b00100101;
      4'h3: return 8'b00001101;
      4'h4: return 8'b10011001;
      4'h5: return 8'b01001001;
      4'h6: return 8'b01000001;
      4'h7: return 8'b00011111;
      4'h8: return 8'b00000001;
      4'h9: return 8'b00011001;
      4'hA: return 8'b00010001;
      4'hB: return 8'b11000001;
      4'hC: return 8'b01100011;
      4'hD: return 8'b10000101;
      4'hE: return 8'b01100001;
      default: return 8'b01110001;
    endcase
  endfunction

  task automatic push_frame(input logic [15:0] v, input logic [3:0] dp);
    logic [3:0] an_e[ND];
    logic [7:0] seg_e[ND];
    logic       seen;
    logic [7:0] pat;
    seen = 1'b0;
    for (int k = ND - 1; k >= 0; k--) begin
      seen = seen | (v[4*k +: 4] != 4'h0) | dp[k];
      if (seen || k == 0) begin
        an_e[k]  = ~(4'b0001 << k);
        pat      = ref_pattern(v[4*k +: 4]);
        seg_e[k] = {pat[7:1], ~dp[k]};
      end else begin
        an_e[k]  = 4'hF;
        seg_e[k] = 8'hFF;
      end
    end
    for (int k = 0; k < ND; k++) begin
      exp_an_q.push_back(an_e[k]);
      exp_seg_q.push_back(seg_e[k]);
    end
  endtask

  task automatic wait_frame(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < 64);
    if (frame_done !== 1'b1) begin
      chk("frame_done timeout", {7'd0, frame_done}, 8'd1);
    end
  endtask

  // Starts on the negedge where frame_done is seen; samples each digit mid-slot.
  task automatic check_frame(input int change_at, input logic [15:0] change_val);
    int need;
    logic [3:0] ea;
    logic [7:0] es;
    for (int k = 0; k < ND; k++) begin
      need = (k == 0) ? 2 : RD;
      for (int j = 0; j < need; j++) begin
        @(negedge clk);
        if (k == 0 && j == 0) chk("frame_done width", {7'd0, frame_done}, 8'd0);
        if (k == change_at && j == need - 2) value = change_val;
      end
      if (exp_an_q.size() == 0) begin
        chk("scoreboard empty", 8'd0, 8'd1);
      end else begin
        ea = exp_an_q.pop_front();
        es = exp_seg_q.pop_front();
        chk($sformatf("an digit%0d", k), {4'd0, an}, {4'd0, ea});
        chk($sformatf("seg digit%0d", k), seg, es);
      end
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    en    = 1'b1;
    value = 16'h0000;
    dp_en = 4'b0000;
    repeat (3) @(negedge clk);
    chk("reset an", {4'd0, an}, 8'h0F);
    chk("reset seg", seg, 8'hFF);
    chk("reset frame_done", {7'd0, frame_done}, 8'd0);

    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset an", {4'd0, an}, 8'h0E);
    chk("post-reset seg", seg, 8'b00000011);
    value = 16'hC0DE;
    wait_frame(n);
    chk("first frame latency", 8'(n), 8'd15);
    push_frame(16'hC0DE, 4'b0000);
    check_frame(-1, 16'h0);
    wait_frame(n);
    wait_frame(n);
    chk("frame period", 8'(n), 8'd16);

    value = 16'h0042;
    wait_frame(n);
    push_frame(16'h0042, 4'b0000);
    check_frame(-1, 16'h0);

    value = 16'h0000;
    wait_frame(n);
    push_frame(16'h0000, 4'b0000);
    check_frame(-1, 16'h0);

    value = 16'h0005;
    dp_en = 4'b0100;
    wait_frame(n);
    push_frame(16'h0005, 4'b0100);
    check_frame(-1, 16'h0);

    value = 16'hAB7F;
    dp_en = 4'b1001;
    wait_frame(n);
    push_frame(16'hAB7F, 4'b1001);
    check_frame(-1, 16'h0);

    value = 16'h1111;
    dp_en = 4'b0000;
    wait_frame(n);
    push_frame(16'h1111, 4'b0000);
    check_frame(-1, 16'h0);
    wait_frame(n);
    push_frame(16'h1111, 4'b0000);
    check_frame(2, 16'h2222);
    wait_frame(n);
    push_frame(16'h2222, 4'b0000);
    check_frame(-1, 16'h0);

    wait_frame(n);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("disabled an", {4'd0, an}, 8'h0F);
    chk("disabled seg", seg, 8'hFF);
    wait_frame(n);
    chk("frame_done while disabled", 8'(n), 8'd14);
    en = 1'b1;
    push_frame(16'h2222, 4'b0000);
    check_frame(-1, 16'h0);

    rst_n = 1'b0;
    @(negedge clk);
    chk("mid-frame reset an", {4'd0, an}, 8'h0F);
    chk("mid-frame reset seg", seg, 8'hFF);
    chk("mid-frame reset frame_done", {7'd0, frame_done}, 8'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart an", {4'd0, an}, 8'h0E);
    chk("restart seg", seg, 8'b00000011);
    wait_frame(n);
    chk("restart frame latency", 8'(n), 8'd15);
    push_frame(16'h2222, 4'b0000);
    check_frame(-1, 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL global timeout: observed running expected finished");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
